fifo_burst_reader: RTL and testbench



---
 rtl/fifo_burst_reader.sv | 110 +++++++++++
 tb/tb_fifo_burst_reader.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains fixed-length bursts from an async FIFO read port onto a valid/ready stream.
//   clk, rst             read-domain clock, synchronous active-high reset
//   fifo_rd_en           FIFO read strobe (data returns one cycle later on fifo_rd_data)
//   fifo_rd_empty        FIFO empty flag
//   fifo_rd_water_level  words resident in the FIFO, sampled only while idle
//   m_data/m_valid/m_ready/m_last  output stream, m_last on the final word of each burst
//   burst_start          one-cycle pulse on the first BURST cycle
//   burst_cnt            completed bursts, wraps
//   underrun_err         sticky empty-while-reads-pending flag; present only when
//                        FIFO_BURST_READER_UNDERRUN_CHECK_EN is defined, otherwise tied 0
module fifo_burst_reader #(
    parameter int DATA_WIDTH  = 128,
    parameter int LEVEL_WIDTH = 6,
    parameter int BURST_LEN   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
    input  logic                   fifo_rd_empty,
    input  logic [LEVEL_WIDTH-1:0] fifo_rd_water_level,
    output logic [DATA_WIDTH-1:0]  m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   m_last,
    output logic                   burst_start,
    output logic [15:0]            burst_cnt,
    output logic                   underrun_err
);
    localparam logic [LEVEL_WIDTH-1:0] BL = LEVEL_WIDTH'(BURST_LEN);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                 state_q, state_d;
    logic [LEVEL_WIDTH-1:0] reads_left_q, reads_left_d;
    logic [LEVEL_WIDTH-1:0] words_left_q, words_left_d;
    logic                   inflight_q;
    logic [2:0]             occ_q, occ_d;
    logic [1:0]             wr_ptr_q, rd_ptr_q;
    logic [DATA_WIDTH-1:0]  buf_q [4];
    logic                   burst_start_q, burst_start_d;
    logic [15:0]            burst_cnt_q, burst_cnt_d;
    logic                   go, accept;

    // Read issue looks only at registered occupancy plus the word in flight, so
    // m_ready never reaches fifo_rd_en combinationally; the <=2 bound keeps the
    // 4-entry skid buffer at most 3 deep while still sustaining one word per cycle.
    always_comb begin
        go            = state_q == IDLE && fifo_rd_water_level >= BL && !fifo_rd_empty;
        m_valid       = occ_q != 3'd0;
        m_data        = m_valid ? buf_q[rd_ptr_q] : '0;
        m_last        = m_valid && words_left_q == LEVEL_WIDTH'(1);
        accept        = m_valid && m_ready;
        fifo_rd_en    = state_q == BURST && reads_left_q != '0 && !fifo_rd_empty &&
                        (occ_q + {2'b0, inflight_q}) <= 3'd2;
        state_d       = go ? BURST : (accept && m_last) ? IDLE : state_q;
        reads_left_d  = go ? BL : reads_left_q - LEVEL_WIDTH'(fifo_rd_en);
        words_left_d  = go ? BL : words_left_q - LEVEL_WIDTH'(accept);
        occ_d         = occ_q + {2'b0, inflight_q} - {2'b0, accept};
        burst_start_d = go;
        burst_cnt_d   = burst_cnt_q + 16'(accept && m_last);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            reads_left_q  <= '0;
            words_left_q  <= '0;
            inflight_q    <= 1'b0;
            occ_q         <= 3'd0;
            wr_ptr_q      <= 2'd0;
            rd_ptr_q      <= 2'd0;
            burst_start_q <= 1'b0;
            burst_cnt_q   <= 16'd0;
        end else begin
            state_q       <= state_d;
            reads_left_q  <= reads_left_d;
            words_left_q  <= words_left_d;
            inflight_q    <= fifo_rd_en;
            occ_q         <= occ_d;
            wr_ptr_q      <= wr_ptr_q + 2'(inflight_q);
            rd_ptr_q      <= rd_ptr_q + 2'(accept);
            burst_start_q <= burst_start_d;
            burst_cnt_q   <= burst_cnt_d;
        end
    end

    // Storage needs no reset: m_data is masked whenever the buffer is empty.
    always_ff @(posedge clk) begin
        if (inflight_q) buf_q[wr_ptr_q] <= fifo_rd_data;
    end

    assign burst_start = burst_start_q;
    assign burst_cnt   = burst_cnt_q;

`ifdef FIFO_BURST_READER_UNDERRUN_CHECK_EN
    logic underrun_q;

    // Empty while reads are still owed means the water level overstated the
    // FIFO contents or another reader drained it.
    always_ff @(posedge clk) begin
        if (rst) underrun_q <= 1'b0;
        else if (state_q == BURST && reads_left_q != '0 && fifo_rd_empty) underrun_q <= 1'b1;
    end

    assign underrun_err = underrun_q;
`else
    assign underrun_err = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: randomized self-checking bench for fifo_burst_reader with a behavioural FIFO and stream model.
module tb_fifo_burst_reader;
    localparam int DW = 128;
    localparam int LW = 6;
    localparam int BL = 16;
`ifdef FIFO_BURST_READER_UNDERRUN_CHECK_EN
    localparam logic UNDERRUN_EXP = 1'b1;
`else
    localparam logic UNDERRUN_EXP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          m_ready = 1'b0, m_ready1 = 1'b0, force_empty = 1'b0;
    logic          fifo_rd_en, fifo_rd_empty, m_valid, m_last, burst_start, underrun_err;
    logic          fifo_rd_en1, fifo_rd_empty1, m_valid1, m_last1, burst_start1, underrun_err1;
    logic [DW-1:0] fifo_rd_data = '0, fifo_rd_data1 = '0, m_data, m_data1;
    logic [LW-1:0] lvl, lvl1;
    logic [15:0]   burst_cnt, burst_cnt1;

    int            pushed0 = 0, popped0 = 0, pushed1 = 0, popped1 = 0;
    logic [DW-1:0] mem0 [1024];
    logic [DW-1:0] mem1 [1024];
    logic [DW-1:0] exp0[$], got0[$], exp1[$], got1[$];
    logic          last0[$];
    int            nvec = 0, nerr = 0, cyc = 0;
    int            starts = 0, rd_cnt = 0, vcyc = 0, stall_viol = 0, nl1 = 0;
    int            first_start = -1, first_valid = -1, last_valid = -1;
    logic          prev_stall = 1'b0, prev_last = 1'b0;
    logic [DW-1:0] prev_data = '0;

    assign lvl            = LW'(pushed0 - popped0);
    assign fifo_rd_empty  = (pushed0 == popped0) || force_empty;
    assign lvl1           = LW'(pushed1 - popped1);
    assign fifo_rd_empty1 = pushed1 == popped1;

    always #5 clk = ~clk;

    fifo_burst_reader #(.DATA_WIDTH(DW), .LEVEL_WIDTH(LW), .BURST_LEN(BL)) dut (
        .clk(clk), .rst(rst),
        .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_rd_empty(fifo_rd_empty),
        .fifo_rd_water_level(lvl),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .burst_start(burst_start), .burst_cnt(burst_cnt), .underrun_err(underrun_err)
    );

    fifo_burst_reader #(.DATA_WIDTH(DW), .LEVEL_WIDTH(LW), .BURST_LEN(1)) dut1 (
        .clk(clk), .rst(rst),
        .fifo_rd_en(fifo_rd_en1), .fifo_rd_data(fifo_rd_data1), .fifo_rd_empty(fifo_rd_empty1),
        .fifo_rd_water_level(lvl1),
        .m_data(m_data1), .m_valid(m_valid1), .m_ready(m_ready1), .m_last(m_last1),
        .burst_start(burst_start1), .burst_cnt(burst_cnt1), .underrun_err(underrun_err1)
    );

    // FIFO read ports: one-cycle latency, no output register.
    always @(posedge clk) begin
        if (fifo_rd_en && popped0 < pushed0) begin
            fifo_rd_data <= mem0[popped0 % 1024];
            popped0      <= popped0 + 1;
        end
        if (fifo_rd_en1 && popped1 < pushed1) begin
            fifo_rd_data1 <= mem1[popped1 % 1024];
            popped1       <= popped1 + 1;
        end
    end

    task automatic push0(input int n, input logic pat);
        logic [DW-1:0] w;
        for (int i = 0; i < n; i++) begin
            w = pat ? ~DW'(i) : {$urandom(), $urandom(), $urandom(), $urandom()};
            mem0[pushed0 % 1024] = w;
            exp0.push_back(w);
            pushed0++;
        end
    endtask

    task automatic push1(input int n);
        logic [DW-1:0] w;
        for (int i = 0; i < n; i++) begin
            w = {$urandom(), $urandom(), $urandom(), $urandom()};
            mem1[pushed1 % 1024] = w;
            exp1.push_back(w);
            pushed1++;
        end
    endtask

    task automatic clear;
        got0.delete(); last0.delete(); exp0.delete();
        starts = 0; rd_cnt = 0; vcyc = 0; stall_viol = 0;
        first_start = -1; first_valid = -1; last_valid = -1;
        prev_stall = 1'b0;
    endtask

    // One clock: drive m_ready, observe the cycle, advance to 1 time unit past the next edge.
    task automatic tick(input logic rdy);
        m_ready  = rdy;
        m_ready1 = rdy;
        #1;
        if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last)) stall_viol++;
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
        if (m_valid && m_ready) begin
            got0.push_back(m_data);
            last0.push_back(m_last);
        end
        if (m_valid) begin
            vcyc++;
            if (first_valid < 0) first_valid = cyc;
            last_valid = cyc;
        end
        if (burst_start) begin
            starts++;
            if (first_start < 0) first_start = cyc;
        end
        if (fifo_rd_en) rd_cnt++;
        if (m_valid1 && m_ready1) begin
            got1.push_back(m_data1);
            if (!m_last1) nl1++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(1'b0);
        tick(1'b0);
        nvec++; if (fifo_rd_en !== 1'b0) begin nerr++; $display("FAIL reset_rd_en: got %b want 0", fifo_rd_en); end
        nvec++; if (m_valid !== 1'b0) begin nerr++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
        nvec++; if (m_last !== 1'b0) begin nerr++; $display("FAIL reset_m_last: got %b want 0", m_last); end
        nvec++; if (burst_start !== 1'b0) begin nerr++; $display("FAIL reset_burst_start: got %b want 0", burst_start); end
        nvec++; if (underrun_err !== 1'b0) begin nerr++; $display("FAIL reset_underrun: got %b want 0", underrun_err); end
        nvec++; if (m_data !== '0) begin nerr++; $display("FAIL reset_m_data: got %h want 0", m_data); end
        nvec++; if (burst_cnt !== 16'd0) begin nerr++; $display("FAIL reset_burst_cnt: got %0d want 0", burst_cnt); end
        nvec++; if (m_valid1 !== 1'b0 || burst_cnt1 !== 16'd0) begin nerr++; $display("FAIL reset_min_inst: got valid %b cnt %0d want 0 0", m_valid1, burst_cnt1); end
        rst = 1'b0;
    endtask

    task automatic test_prefill_drain;
        int pc;
        clear();
        push0(16, 1'b1);
        pc = cyc;
        for (int t = 0; t < 40; t++) tick(1'b1);
        nvec++; if (first_start - pc !== 1) begin nerr++; $display("FAIL prefill_start_latency: got %0d want 1", first_start - pc); end
        nvec++; if (first_valid - pc !== 3) begin nerr++; $display("FAIL prefill_valid_latency: got %0d want 3", first_valid - pc); end
        nvec++; if (vcyc !== 16 || last_valid - first_valid !== 15) begin nerr++; $display("FAIL prefill_valid_run: got %0d cycles span %0d want 16 span 15", vcyc, last_valid - first_valid); end
        nvec++; if (starts !== 1) begin nerr++; $display("FAIL prefill_starts: got %0d want 1", starts); end
        nvec++; if (rd_cnt !== 16) begin nerr++; $display("FAIL prefill_reads: got %0d want 16", rd_cnt); end
        nvec++; if (burst_cnt !== 16'd1) begin nerr++; $display("FAIL prefill_burst_cnt: got %0d want 1", burst_cnt); end
        nvec++; if (got0.size() !== exp0.size()) begin nerr++; $display("FAIL prefill_count: got %0d want %0d", got0.size(), exp0.size()); end
        for (int i = 0; i < got0.size() && i < exp0.size(); i++) begin
            nvec++;
            if (got0[i] !== exp0[i] || last0[i] !== (i % BL == BL - 1)) begin
                nerr++;
                $display("FAIL prefill_word%0d: got %h last %b want %h last %b", i, got0[i], last0[i], exp0[i], i % BL == BL - 1);
            end
        end
    endtask

    task automatic test_below_threshold;
        clear();
        push0(BL - 1, 1'b0);
        for (int t = 0; t < 100; t++) tick(1'b1);
        nvec++; if (rd_cnt !== 0 || vcyc !== 0 || starts !== 0) begin nerr++; $display("FAIL below_idle: got reads %0d valids %0d starts %0d want 0 0 0", rd_cnt, vcyc, starts); end
        push0(1, 1'b0);
        for (int t = 0; t < 40; t++) tick(1'b1);
        nvec++; if (starts !== 1 || burst_cnt !== 16'd2) begin nerr++; $display("FAIL below_burst: got starts %0d cnt %0d want 1 2", starts, burst_cnt); end
        nvec++; if (got0.size() !== exp0.size()) begin nerr++; $display("FAIL below_count: got %0d want %0d", got0.size(), exp0.size()); end
        for (int i = 0; i < got0.size() && i < exp0.size(); i++) begin
            nvec++;
            if (got0[i] !== exp0[i] || last0[i] !== (i % BL == BL - 1)) begin
                nerr++;
                $display("FAIL below_word%0d: got %h last %b want %h last %b", i, got0[i], last0[i], exp0[i], i % BL == BL - 1);
            end
        end
    endtask

    task automatic test_backpressure;
        int t;
        clear();
        push0(2 * BL, 1'b0);
        t = 0;
        while (got0.size() < 2 * BL && t < 600) begin
            tick(1'($urandom_range(0, 1)));
            t++;
        end
        nvec++; if (t >= 600) begin nerr++; $display("FAIL bp_timeout: got %0d words want %0d", got0.size(), 2 * BL); end
        nvec++; if (starts !== 2 || burst_cnt !== 16'd4) begin nerr++; $display("FAIL bp_bursts: got starts %0d cnt %0d want 2 4", starts, burst_cnt); end
        nvec++; if (stall_viol !== 0) begin nerr++; $display("FAIL bp_stall_stable: got %0d violations want 0", stall_viol); end
        nvec++; if (got0.size() !== exp0.size()) begin nerr++; $display("FAIL bp_count: got %0d want %0d", got0.size(), exp0.size()); end
        for (int i = 0; i < got0.size() && i < exp0.size(); i++) begin
            nvec++;
            if (got0[i] !== exp0[i] || last0[i] !== (i % BL == BL - 1)) begin
                nerr++;
                $display("FAIL bp_word%0d: got %h last %b want %h last %b", i, got0[i], last0[i], exp0[i], i % BL == BL - 1);
            end
        end
    endtask

    task automatic test_forced_empty;
        int t, fe;
        clear();
        push0(BL, 1'b0);
        t = 0;
        while (got0.size() < 5 && t < 50) begin
            tick(1'b1);
            t++;
        end
        force_empty = 1'b1;
        fe = rd_cnt;
        for (int k = 0; k < 5; k++) tick(1'b1);
        fe = rd_cnt - fe;
        force_empty = 1'b0;
        while (got0.size() < BL && t < 200) begin
            tick(1'($urandom_range(0, 1)));
            t++;
        end
        nvec++; if (fe !== 0) begin nerr++; $display("FAIL fe_rd_en_low: got %0d reads want 0", fe); end
        nvec++; if (underrun_err !== UNDERRUN_EXP) begin nerr++; $display("FAIL fe_underrun: got %b want %b", underrun_err, UNDERRUN_EXP); end
        nvec++; if (burst_cnt !== 16'd5) begin nerr++; $display("FAIL fe_burst_cnt: got %0d want 5", burst_cnt); end
        nvec++; if (got0.size() !== exp0.size()) begin nerr++; $display("FAIL fe_count: got %0d want %0d", got0.size(), exp0.size()); end
        for (int i = 0; i < got0.size() && i < exp0.size(); i++) begin
            nvec++;
            if (got0[i] !== exp0[i] || last0[i] !== (i == BL - 1)) begin
                nerr++;
                $display("FAIL fe_word%0d: got %h last %b want %h last %b", i, got0[i], last0[i], exp0[i], i == BL - 1);
            end
        end
    endtask

    task automatic test_reset_mid_burst;
        int t;
        clear();
        push0(BL, 1'b0);
        t = 0;
        while (got0.size() < 5 && t < 50) begin
            tick(1'b1);
            t++;
        end
        rst = 1'b1;
        tick(1'b1);
        nvec++; if (fifo_rd_en !== 1'b0 || m_valid !== 1'b0 || m_last !== 1'b0 || burst_start !== 1'b0) begin
            nerr++; $display("FAIL rstmid_ctrl: got rd_en %b valid %b last %b start %b want 0 0 0 0", fifo_rd_en, m_valid, m_last, burst_start);
        end
        nvec++; if (m_data !== '0 || burst_cnt !== 16'd0 || underrun_err !== 1'b0) begin
            nerr++; $display("FAIL rstmid_data: got data %h cnt %0d err %b want 0 0 0", m_data, burst_cnt, underrun_err);
        end
        rst = 1'b0;
        pushed0 = popped0;
        clear();
        push0(BL, 1'b0);
        for (int k = 0; k < 40; k++) tick(1'b1);
        nvec++; if (starts !== 1 || burst_cnt !== 16'd1) begin nerr++; $display("FAIL rstmid_refill: got starts %0d cnt %0d want 1 1", starts, burst_cnt); end
        nvec++; if (got0.size() !== exp0.size()) begin nerr++; $display("FAIL rstmid_count: got %0d want %0d", got0.size(), exp0.size()); end
        for (int i = 0; i < got0.size() && i < exp0.size(); i++) begin
            nvec++;
            if (got0[i] !== exp0[i] || last0[i] !== (i == BL - 1)) begin
                nerr++;
                $display("FAIL rstmid_word%0d: got %h last %b want %h last %b", i, got0[i], last0[i], exp0[i], i == BL - 1);
            end
        end
    endtask

    task automatic test_min_burst;
        int t;
        got1.delete();
        exp1.delete();
        nl1 = 0;
        push1(8);
        t = 0;
        while (got1.size() < 8 && t < 200) begin
            tick(1'($urandom_range(0, 1)));
            t++;
        end
        nvec++; if (t >= 200) begin nerr++; $display("FAIL min_timeout: got %0d words want 8", got1.size()); end
        nvec++; if (nl1 !== 0) begin nerr++; $display("FAIL min_last: got %0d words without last want 0", nl1); end
        nvec++; if (burst_cnt1 !== 16'd8) begin nerr++; $display("FAIL min_burst_cnt: got %0d want 8", burst_cnt1); end
        for (int i = 0; i < got1.size() && i < exp1.size(); i++) begin
            nvec++;
            if (got1[i] !== exp1[i]) begin nerr++; $display("FAIL min_word%0d: got %h want %h", i, got1[i], exp1[i]); end
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_prefill_drain();
        test_below_threshold();
        test_backpressure();
        test_forced_empty();
        test_reset_mid_burst();
        test_min_burst();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
